ethernet_transmitter: RTL

Transmit-side counterpart of the Ethernet receive path: the host writes an outgoing frame into a two-slot internal packet buffer, commits it with a byte length, and the block streams committed frames, in commit order, onto an AXI-Stream master toward the MAC. It sits between the host-facing register/memory interface and the MAC TX AXIS input, and exports a count of transmitted frames.

---
 rtl/ethernet_transmitter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/ethernet_transmitter.sv
// ethernet_transmitter
//   Host-side frame buffer plus AXI-Stream transmitter toward the MAC.
//   The host fills the open slot of a two-slot ring, latches a byte length
//   and commits; committed frames stream out in commit order.
//
// Ports
//   clk_i, reset_i            sole clock, synchronous active-high reset
//   packet_req_o              a free slot is open for host writes
//   packet_wvalid_i/waddr_i/wdata_i/wdata_size_i
//                             byte-addressed write (2^size bytes, aligned)
//   packet_wsize_valid_i/wsize_i  latch frame length of the open slot
//   packet_send_i             commit the open slot
//   tx_axis_*                 AXI-Stream master toward the MAC
//   transmit_count_o          frames fully handed to AXIS (wrapping)
module ethernet_transmitter #(
    parameter int data_width_p = 32,
    parameter int eth_mtu_p    = 2048,
    parameter int send_count_p = 65535,
    localparam int bytes_lp             = data_width_p / 8,
    localparam int addr_width_lp        = $clog2(eth_mtu_p),
    localparam int size_width_lp        = $clog2(((bytes_lp == 1) ? 1 : $clog2(bytes_lp)) + 1),
    localparam int packet_size_width_lp = $clog2(eth_mtu_p + 1),
    localparam int count_width_lp       = $clog2(send_count_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    output logic                            packet_req_o,
    input  logic                            packet_wvalid_i,
    input  logic [addr_width_lp-1:0]        packet_waddr_i,
    input  logic [data_width_p-1:0]         packet_wdata_i,
    input  logic [size_width_lp-1:0]        packet_wdata_size_i,
    input  logic                            packet_wsize_valid_i,
    input  logic [packet_size_width_lp-1:0] packet_wsize_i,
    input  logic                            packet_send_i,
    output logic [data_width_p-1:0]         tx_axis_tdata_o,
    output logic [bytes_lp-1:0]             tx_axis_tkeep_o,
    output logic                            tx_axis_tvalid_o,
    input  logic                            tx_axis_tready_i,
    output logic                            tx_axis_tlast_o,
    output logic                            tx_axis_tuser_o,
    output logic [count_width_lp-1:0]       transmit_count_o
);

    localparam int lg_bytes_lp   = $clog2(bytes_lp);
    localparam int words_lp      = eth_mtu_p / bytes_lp;
    localparam int word_width_lp = addr_width_lp - lg_bytes_lp;

    typedef enum logic [1:0] {TX_IDLE, TX_FETCH, TX_SEND} tx_state_e;

    tx_state_e state_r, state_n;

    logic [data_width_p-1:0]         mem_r [2*words_lp];
    logic [packet_size_width_lp-1:0] slot_len_r [2];
    logic [packet_size_width_lp-1:0] cur_len_r, eff_len;
    logic                            wr_ptr_r, rd_ptr_r;
    logic [1:0]                      occ_r, occ_n;
    logic [count_width_lp-1:0]       count_r;

    logic wr_fire, size_fire, send_fire, commit;

    logic [lg_bytes_lp-1:0]  wr_off;
    logic [31:0]             wr_off_u, wr_end_u;
    logic [bytes_lp-1:0]     wr_mask;
    logic [data_width_p-1:0] wr_data;
    logic [word_width_lp:0]  wr_idx;

    logic [packet_size_width_lp-1:0] frame_len, frame_beats;
    logic [lg_bytes_lp-1:0]          frame_rem;
    logic [bytes_lp-1:0]             last_keep;
    logic [word_width_lp-1:0]        fetch_word_r, push_word;
    logic [packet_size_width_lp-1:0] fetch_left_r;
    logic [word_width_lp:0]          rd_idx;

    // Two-entry output skid; entries never change while they are queued.
    logic [data_width_p-1:0] skid_data_r [2];
    logic [bytes_lp-1:0]     skid_keep_r [2];
    logic                    skid_last_r [2];
    logic                    skid_head_r, push_slot;
    logic [1:0]              skid_cnt_r, skid_cnt_n;
    logic                    push, push_last, pop, done;
    logic [bytes_lp-1:0]     push_keep;

    // Host side
    always_comb begin
        packet_req_o = ~reset_i & (occ_r != 2'd2);
        wr_fire      = packet_wvalid_i & packet_req_o;
        size_fire    = packet_wsize_valid_i & packet_req_o;
        send_fire    = packet_send_i & packet_req_o;
        eff_len      = size_fire ? packet_wsize_i : cur_len_r;
        // A zero-length commit never occupies the slot, so it simply stays open.
        commit       = send_fire & (eff_len != '0);

        wr_off   = packet_waddr_i[lg_bytes_lp-1:0];
        wr_off_u = 32'(wr_off);
        wr_end_u = wr_off_u + (32'd1 << packet_wdata_size_i);
        wr_idx   = {wr_ptr_r, packet_waddr_i[addr_width_lp-1:lg_bytes_lp]};
        wr_data  = packet_wdata_i << {wr_off, 3'b000};
        wr_mask  = '0;
        for (int unsigned b = 0; b < bytes_lp; b++) begin
            wr_mask[b] = (b >= wr_off_u) && (b < wr_end_u);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            for (int unsigned b = 0; b < bytes_lp; b++) begin
                if (wr_mask[b]) begin
                    mem_r[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Frame geometry of the oldest committed slot
    always_comb begin
        frame_len   = slot_len_r[rd_ptr_r];
        frame_beats = (frame_len + packet_size_width_lp'(bytes_lp - 1)) >> lg_bytes_lp;
        frame_rem   = frame_len[lg_bytes_lp-1:0];
        last_keep   = '0;
        for (int unsigned b = 0; b < bytes_lp; b++) begin
            last_keep[b] = (frame_rem == '0) || (b < 32'(frame_rem));
        end
    end

    // TX FSM and skid control
    always_comb begin
        pop   = (skid_cnt_r != 2'd0) & tx_axis_tready_i;
        done  = pop & skid_last_r[skid_head_r];
        occ_n = occ_r + 2'(commit) - 2'(done);

        state_n   = state_r;
        push      = 1'b0;
        push_last = 1'b0;
        push_word = fetch_word_r;

        case (state_r)
            TX_IDLE: begin
                if (occ_n != 2'd0) state_n = TX_FETCH;
            end
            TX_FETCH: begin
                push      = 1'b1;
                push_word = '0;
                push_last = (frame_beats == packet_size_width_lp'(1));
                state_n   = TX_SEND;
            end
            TX_SEND: begin
                // Fetch only while the skid has room without looking at tready,
                // so the memory read never waits on the downstream handshake.
                if ((fetch_left_r != '0) && (skid_cnt_r != 2'd2)) begin
                    push      = 1'b1;
                    push_last = (fetch_left_r == packet_size_width_lp'(1));
                end
                // Skipping IDLE here keeps the inter-frame gap to one cycle.
                if (done) state_n = (occ_n != 2'd0) ? TX_FETCH : TX_IDLE;
            end
            default: state_n = TX_IDLE;
        endcase

        push_keep  = push_last ? last_keep : '1;
        push_slot  = skid_head_r ^ skid_cnt_r[0];
        skid_cnt_n = skid_cnt_r + 2'(push) - 2'(pop);
        rd_idx     = {rd_ptr_r, push_word};
    end

    // Synchronous memory read lands directly in the skid entry.
    always_ff @(posedge clk_i) begin
        if (push) skid_data_r[push_slot] <= mem_r[rd_idx];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= TX_IDLE;
            cur_len_r    <= '0;
            slot_len_r   <= '{default: '0};
            wr_ptr_r     <= 1'b0;
            rd_ptr_r     <= 1'b0;
            occ_r        <= 2'd0;
            count_r      <= '0;
            fetch_word_r <= '0;
            fetch_left_r <= '0;
            skid_keep_r  <= '{default: '0};
            skid_last_r  <= '{default: 1'b0};
            skid_head_r  <= 1'b0;
            skid_cnt_r   <= 2'd0;
        end else begin
            state_r <= state_n;
            occ_r   <= occ_n;
            if (size_fire) cur_len_r <= packet_wsize_i;
            if (commit) begin
                slot_len_r[wr_ptr_r] <= eff_len;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (done) begin
                rd_ptr_r <= ~rd_ptr_r;
                count_r  <= (count_r == count_width_lp'(send_count_p)) ? '0 : count_r + 1'b1;
            end
            if (state_r == TX_FETCH) begin
                fetch_left_r <= frame_beats - 1'b1;
                fetch_word_r <= word_width_lp'(1);
            end else if (push) begin
                fetch_left_r <= fetch_left_r - 1'b1;
                fetch_word_r <= fetch_word_r + 1'b1;
            end
            if (push) begin
                skid_keep_r[push_slot] <= push_keep;
                skid_last_r[push_slot] <= push_last;
            end
            if (pop) skid_head_r <= ~skid_head_r;
            skid_cnt_r <= skid_cnt_n;
        end
    end

    // AXIS outputs; bytes outside tkeep are forced to zero.
    always_comb begin
        tx_axis_tvalid_o = (skid_cnt_r != 2'd0);
        tx_axis_tdata_o  = '0;
        tx_axis_tkeep_o  = '0;
        tx_axis_tlast_o  = 1'b0;
        tx_axis_tuser_o  = 1'b0;
        if (tx_axis_tvalid_o) begin
            tx_axis_tkeep_o = skid_keep_r[skid_head_r];
            tx_axis_tlast_o = skid_last_r[skid_head_r];
            for (int unsigned b = 0; b < bytes_lp; b++) begin
                if (skid_keep_r[skid_head_r][b]) begin
                    tx_axis_tdata_o[8*b +: 8] = skid_data_r[skid_head_r][8*b +: 8];
                end
            end
        end
        transmit_count_o = count_r;
    end

    a_write_open: assert property (@(posedge clk_i) disable iff (reset_i)
        packet_wvalid_i |-> packet_req_o);
    a_size_open: assert property (@(posedge clk_i) disable iff (reset_i)
        packet_wsize_valid_i |-> packet_req_o);
    a_send_open: assert property (@(posedge clk_i) disable iff (reset_i)
        packet_send_i |-> packet_req_o);

endmodule
